// File: rtl/gate_chk_pkg.sv
// Shared types and constants for the gate-bank vector checker.
package gate_chk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int NUM_VEC = 4;

    // Bit positions of the gate outputs inside the {p,q,r,s} word
    localparam int P = 3;
    localparam int Q = 2;
    localparam int R = 1;
    localparam int S = 0;

endpackage

// File: rtl/gate_expect.sv
// Golden truth table: expected {p,q,r,s} = {~a, a&b, a|b, a^b}.
module gate_expect
    import gate_chk_pkg::*;
(
    input  logic       a_i,
    input  logic       b_i,
    output logic [3:0] exp_o
);

    // Combinational golden model of the gate bank
    always_comb begin
        exp_o    = 4'b0000;
        exp_o[P] = ~a_i;
        exp_o[Q] = a_i & b_i;
        exp_o[R] = a_i | b_i;
        exp_o[S] = a_i ^ b_i;
    end

endmodule

// File: rtl/gate_vector_checker.sv
// Steps a gate bank through all four input vectors, compares its outputs
// against the golden model and accumulates a mismatch count and mask.
module gate_vector_checker
    import gate_chk_pkg::*;
#(
    parameter int SETTLE = 1,
    parameter int ERR_W  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             p,
    input  logic             q,
    input  logic             r,
    input  logic             s,
    output logic             a,
    output logic             b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [3:0]       fail_vec
);

    localparam int               CNT_W       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};
    localparam logic [1:0]       LAST_VEC    = 2'(NUM_VEC - 1);

    state_e           state_q;
    logic [1:0]       vec_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic [ERR_W-1:0] err_q;
    logic [3:0]       fail_q;

    logic [3:0]       exp_s;
    logic [3:0]       obs_s;
    logic             mismatch_s;
    logic [ERR_W-1:0] err_d;

    // vec_q is the value on {a,b}; it is zero outside a run
    gate_expect u_expect (
        .a_i   (vec_q[1]),
        .b_i   (vec_q[0]),
        .exp_o (exp_s)
    );

    // Compare the sampled gate outputs and form the saturating next count
    always_comb begin
        obs_s      = 4'b0000;
        obs_s[P]   = p;
        obs_s[Q]   = q;
        obs_s[R]   = r;
        obs_s[S]   = s;
        mismatch_s = (obs_s != exp_s);
        if (mismatch_s && (err_q != ERR_MAX)) begin
            err_d = err_q + ERR_W'(1);
        end else begin
            err_d = err_q;
        end
    end

    // Sequencing FSM with all result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            vec_q   <= 2'd0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fail_q  <= 4'b0000;
        end else begin
            case (state_q)
                IDLE: begin
                    vec_q <= 2'd0;
                    if (start) begin
                        err_q   <= '0;
                        fail_q  <= 4'b0000;
                        pass_q  <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_q   <= '0;
                        state_q <= CHECK;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                CHECK: begin
                    err_q <= err_d;
                    if (mismatch_s) begin
                        fail_q[vec_q] <= 1'b1;
                    end
                    if (vec_q == LAST_VEC) begin
                        // pass reflects the count including this final check
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_d == '0);
                        state_q <= DONE;
                    end else begin
                        vec_q   <= vec_q + 2'd1;
                        state_q <= DRIVE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    vec_q   <= 2'd0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign a        = vec_q[1];
    assign b        = vec_q[0];
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign err_cnt  = err_q;
    assign fail_vec = fail_q;

endmodule

// File: tb/tb_gate_vector_checker.sv
// Self-checking bench: three checker instances, each driving a behavioural
// gate bank with programmable per-vector faults.
module tb_gate_vector_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [2:0] start_s;
    wire  [2:0] a_s, b_s, busy_s, done_s, pass_s;
    wire  [2:0] err0_s, err2_s;
    wire  [1:0] err1_s;
    wire  [3:0] fv_s   [3];
    wire  [3:0] bank_s [3];

    logic [3:0] amask [3][4];
    logic [3:0] xmask [3][4];

    int total = 0;
    int bad   = 0;
    int cur_idx = 0;

    // Gate behaviour from counting the ones on the inputs
    function automatic logic [3:0] truth(input logic [1:0] v);
        int ones;
        ones = int'(v[1]) + int'(v[0]);
        return {~v[1], ones == 2, ones >= 1, ones == 1};
    endfunction

    for (genvar i = 0; i < 3; i++) begin : g_bank
        assign bank_s[i] = (truth({a_s[i], b_s[i]}) & amask[i][{a_s[i], b_s[i]}])
                           ^ xmask[i][{a_s[i], b_s[i]}];
    end

    gate_vector_checker #(.SETTLE(1), .ERR_W(3)) dut0 (
        .clk(clk), .reset(reset), .start(start_s[0]),
        .p(bank_s[0][3]), .q(bank_s[0][2]), .r(bank_s[0][1]), .s(bank_s[0][0]),
        .a(a_s[0]), .b(b_s[0]), .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]),
        .err_cnt(err0_s), .fail_vec(fv_s[0])
    );

    gate_vector_checker #(.SETTLE(1), .ERR_W(2)) dut1 (
        .clk(clk), .reset(reset), .start(start_s[1]),
        .p(bank_s[1][3]), .q(bank_s[1][2]), .r(bank_s[1][1]), .s(bank_s[1][0]),
        .a(a_s[1]), .b(b_s[1]), .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]),
        .err_cnt(err1_s), .fail_vec(fv_s[1])
    );

    gate_vector_checker #(.SETTLE(3), .ERR_W(3)) dut2 (
        .clk(clk), .reset(reset), .start(start_s[2]),
        .p(bank_s[2][3]), .q(bank_s[2][2]), .r(bank_s[2][1]), .s(bank_s[2][0]),
        .a(a_s[2]), .b(b_s[2]), .busy(busy_s[2]), .done(done_s[2]), .pass(pass_s[2]),
        .err_cnt(err2_s), .fail_vec(fv_s[2])
    );

    function automatic logic [31:0] get_err(input int idx);
        case (idx)
            0:       return {29'd0, err0_s};
            1:       return {30'd0, err1_s};
            default: return {29'd0, err2_s};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s inst=%0d observed=%0h expected=%0h", tag, cur_idx, obs, exp_v);
        end
    endtask

    task automatic clear_masks(input int idx);
        for (int v = 0; v < 4; v++) begin
            amask[idx][v] = 4'hF;
            xmask[idx][v] = 4'h0;
        end
    endtask

    task automatic rand_masks(input int idx);
        for (int v = 0; v < 4; v++) begin
            xmask[idx][v] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            amask[idx][v] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
        end
    endtask

    // One run: start at cycle 0, optional re-pulses of start, optional reset cycle
    task automatic run(input int idx, input int st, input int emax,
                       input int rp1, input int rp2, input int rst_at);
        int          cnt;
        int          last;
        logic [3:0]  fv_exp;
        logic [31:0] err_exp;
        logic [3:0]  tv;
        cur_idx = idx;
        cnt     = 0;
        fv_exp  = 4'b0000;
        for (int v = 0; v < 4; v++) begin
            tv = truth(2'(v));
            if (((tv & amask[idx][v]) ^ xmask[idx][v]) !== tv) begin
                cnt++;
                fv_exp[v] = 1'b1;
            end
        end
        err_exp = (cnt > emax) ? emax : cnt;
        last    = 4 * (st + 1) + 1;
        start_s[idx] = 1'b1;
        for (int n = 1; n <= last + 2; n++) begin
            @(negedge clk);
            start_s[idx] = (n == rp1) || (n == rp2);
            reset        = (n == rst_at);
            if (rst_at >= 0 && n > rst_at) begin
                chk("rst_busy", 32'(busy_s[idx]), 32'd0);
                chk("rst_done", 32'(done_s[idx]), 32'd0);
                chk("rst_ab", 32'({a_s[idx], b_s[idx]}), 32'd0);
                if (n == rst_at + 1) begin
                    chk("rst_err", get_err(idx), 32'd0);
                    chk("rst_fv", 32'(fv_s[idx]), 32'd0);
                    chk("rst_pass", 32'(pass_s[idx]), 32'd0);
                end
            end else if (n < last) begin
                chk("vec_ab", 32'({a_s[idx], b_s[idx]}), 32'((n - 1) / (st + 1)));
                chk("busy", 32'(busy_s[idx]), 32'd1);
                chk("done_early", 32'(done_s[idx]), 32'd0);
                if (n == 1) begin
                    chk("start_err", get_err(idx), 32'd0);
                    chk("start_fv", 32'(fv_s[idx]), 32'd0);
                    chk("start_pass", 32'(pass_s[idx]), 32'd0);
                end
            end else if (n == last) begin
                chk("done", 32'(done_s[idx]), 32'd1);
                chk("done_busy", 32'(busy_s[idx]), 32'd0);
                chk("done_ab", 32'({a_s[idx], b_s[idx]}), 32'd3);
                chk("pass", 32'(pass_s[idx]), 32'(cnt == 0));
                chk("err_cnt", get_err(idx), err_exp);
                chk("fail_vec", 32'(fv_s[idx]), 32'(fv_exp));
            end else begin
                chk("post_done", 32'(done_s[idx]), 32'd0);
                chk("post_busy", 32'(busy_s[idx]), 32'd0);
                chk("post_ab", 32'({a_s[idx], b_s[idx]}), 32'd0);
                chk("hold_pass", 32'(pass_s[idx]), 32'(cnt == 0));
                chk("hold_err", get_err(idx), err_exp);
                chk("hold_fv", 32'(fv_s[idx]), 32'(fv_exp));
            end
        end
        start_s[idx] = 1'b0;
        reset        = 1'b0;
    endtask

    initial begin
        int idx;
        reset   = 1'b1;
        start_s = 3'b000;
        for (int i = 0; i < 3; i++) clear_masks(i);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            cur_idx = i;
            chk("init_ab", 32'({a_s[i], b_s[i]}), 32'd0);
            chk("init_busy", 32'(busy_s[i]), 32'd0);
            chk("init_done", 32'(done_s[i]), 32'd0);
            chk("init_pass", 32'(pass_s[i]), 32'd0);
            chk("init_err", get_err(i), 32'd0);
            chk("init_fv", 32'(fv_s[i]), 32'd0);
        end
        reset = 1'b0;
        @(negedge clk);

        run(0, 1, 7, -1, -1, -1);

        for (int v = 0; v < 4; v++) amask[0][v] = 4'b1110;
        run(0, 1, 7, -1, -1, -1);

        for (int v = 0; v < 4; v++) xmask[1][v] = 4'b1111;
        run(1, 1, 3, -1, -1, -1);

        clear_masks(0);
        run(0, 1, 7, 3, 9, -1);

        rand_masks(0);
        xmask[0][0] = 4'b0010;
        run(0, 1, 7, -1, -1, 5);
        clear_masks(0);
        run(0, 1, 7, -1, -1, -1);

        run(2, 3, 7, -1, -1, -1);

        for (int it = 0; it < 9; it++) begin
            idx = it % 3;
            rand_masks(idx);
            run(idx, (idx == 2) ? 3 : 1, (idx == 1) ? 3 : 7, -1, -1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
